// File: rtl/buffer_read_sequencer.sv
// ----------------------------------------------------------------------------
// buffer_read_sequencer
//
// Walks `length` rows of the operand buffer starting at `base_addr`, reads
// each row through the buffer's combinational read port and registers it into
// a one-entry valid/ready output stage that feeds the PE array. With
// skip_zero set, all-zero rows are dropped and counted instead of emitted.
//
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   start         pass request, only honoured in IDLE
//   base_addr     first row address (latched on start)
//   length        number of rows (latched on start, 0 allowed)
//   skip_zero     drop all-zero rows (latched on start)
//   buf_ready     buffer holds valid data
//   buf_rd_en     buffer read strobe
//   buf_rd_addr   buffer read address
//   buf_data      buffer read data, combinational from buf_rd_addr
//   out_valid     output beat valid
//   out_ready     PE array accepts the beat
//   out_data      row payload
//   out_idx       row offset from base_addr
//   out_last      beat carries the final row of the pass
//   busy          high whenever the sequencer is not idle
//   done          one-cycle completion pulse
//   skipped_cnt   zero rows dropped in the current/last pass
// ----------------------------------------------------------------------------
module buffer_read_sequencer #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 6,
    parameter int LEN_WIDTH  = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  length,
    input  logic                  skip_zero,
    input  logic                  buf_ready,
    output logic                  buf_rd_en,
    output logic [ADDR_WIDTH-1:0] buf_rd_addr,
    input  logic [DATA_WIDTH-1:0] buf_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [LEN_WIDTH-1:0]  out_idx,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic [LEN_WIDTH-1:0]  skipped_cnt
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_RDY = 3'd1,
        S_FETCH    = 3'd2,
        S_DRAIN    = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    localparam logic [LEN_WIDTH-1:0]  LEN_ZERO  = {LEN_WIDTH{1'b0}};
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE   = LEN_WIDTH'(1'b1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1'b1);
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

    // True when a row carries no non-zero operand.
    function automatic logic row_is_zero(input logic [DATA_WIDTH-1:0] row);
        return (row == DATA_ZERO);
    endfunction

    state_t                  state_q, state_d;
    logic [LEN_WIDTH-1:0]    len_q, len_d;
    logic                    skip_q, skip_d;
    logic [LEN_WIDTH-1:0]    i_q, i_d;
    // Read address runs alongside i (base+i); it wraps naturally at 2^ADDR_WIDTH.
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic [LEN_WIDTH-1:0]    out_idx_q, out_idx_d;
    logic                    out_last_q, out_last_d;
    logic [LEN_WIDTH-1:0]    skipped_q, skipped_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic load_s;
    logic take_s;
    logic last_row_s;
    logic emit_s;

    // A row is fetched whenever the output stage is empty or being emptied this cycle.
    assign load_s     = (state_q == S_FETCH) && (!out_valid_q || out_ready);
    assign take_s     = out_valid_q && out_ready;
    assign last_row_s = (i_q == (len_q - LEN_ONE));
    assign emit_s     = !(skip_q && row_is_zero(buf_data));

    // Next-state, datapath and status computation.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        skip_d      = skip_q;
        i_d         = i_q;
        addr_d      = addr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        skipped_d   = skipped_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d     = length;
                    skip_d    = skip_zero;
                    i_d       = LEN_ZERO;
                    addr_d    = base_addr;
                    skipped_d = LEN_ZERO;
                    if (length == LEN_ZERO) begin
                        state_d = S_DONE;
                    end else if (buf_ready) begin
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WAIT_RDY;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT_RDY: begin
                if (buf_ready) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_WAIT_RDY;
                end
            end
            S_FETCH: begin
                // buf_ready is not re-checked: the buffer only clears on reset.
                if (load_s && last_row_s) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DRAIN: begin
                // Leave as soon as the stage will be empty after this edge.
                if (!out_valid_q || out_ready) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (load_s) begin
            i_d    = i_q + LEN_ONE;
            addr_d = addr_q + ADDR_ONE;
            if (emit_s) begin
                out_valid_d = 1'b1;
                out_data_d  = buf_data;
                out_idx_d   = i_q;
                out_last_d  = last_row_s;
            end else begin
                // Load implies any held beat is being taken, so the stage empties.
                out_valid_d = 1'b0;
                skipped_d   = skipped_q + LEN_ONE;
            end
        end else if (take_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            len_q       <= LEN_ZERO;
            skip_q      <= 1'b0;
            i_q         <= LEN_ZERO;
            addr_q      <= ADDR_ZERO;
            out_valid_q <= 1'b0;
            out_data_q  <= DATA_ZERO;
            out_idx_q   <= LEN_ZERO;
            out_last_q  <= 1'b0;
            skipped_q   <= LEN_ZERO;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            skip_q      <= skip_d;
            i_q         <= i_d;
            addr_q      <= addr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            skipped_q   <= skipped_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign buf_rd_en   = load_s;
    assign buf_rd_addr = addr_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_idx     = out_idx_q;
    assign out_last    = out_last_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign skipped_cnt = skipped_q;

endmodule
